// File: rtl/host_mmio_monitor.sv
// Host MMIO monitor: console FIFOs, finish/exit-code capture and a retirement watchdog.
// Optional cycle counter is built when HOST_MON_CYCLE_CNT_EN is defined.
module host_mmio_monitor #(
  parameter int              XLEN         = 32,
  parameter int              NUM_CHAN     = 2,
  parameter logic [XLEN-1:0] CONSOLE_BASE = 32'h0020_0000,
  parameter logic [XLEN-1:0] FINISH_ADDR  = 32'h1000_0000,
  parameter int              FIFO_DEPTH   = 8,
  parameter int              WDT_WIDTH    = 32
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  st_valid,
  input  logic [XLEN-1:0]       st_addr,
  input  logic [XLEN-1:0]       st_data,
  input  logic                  retire,
  input  logic [WDT_WIDTH-1:0]  wdt_limit,
  output logic [NUM_CHAN-1:0]   con_valid,
  output logic [8*NUM_CHAN-1:0] con_data,
  input  logic [NUM_CHAN-1:0]   con_ready,
  output logic [NUM_CHAN-1:0]   con_overflow,
  output logic                  finish,
  output logic [XLEN-1:0]       exit_code,
  output logic                  hang,
  output logic [31:0]           cycle_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2,
    HUNG  = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [PW-1:0]         r_wr [NUM_CHAN];
  logic [PW-1:0]         r_rd [NUM_CHAN];
  logic [PW-1:0]         w_rd_nxt [NUM_CHAN];
  logic [7:0]            r_mem [NUM_CHAN][FIFO_DEPTH];
  logic [NUM_CHAN-1:0]   w_push;
  logic [NUM_CHAN-1:0]   w_pop;
  logic [NUM_CHAN-1:0]   w_full;
  logic [NUM_CHAN-1:0]   w_empty;
  logic [NUM_CHAN-1:0]   w_accept;
  logic                  w_all_empty;
  logic                  w_finish_st;
  logic                  w_expire;
  logic [WDT_WIDTH-1:0]  r_wdt;
  logic [NUM_CHAN-1:0]   r_con_valid;
  logic [8*NUM_CHAN-1:0] r_con_data;
  logic [NUM_CHAN-1:0]   r_ovf;
  logic [XLEN-1:0]       r_exit;

  // Address decode and FIFO status; fullness uses pre-pop pointers so a full FIFO drops the push.
  always_comb begin
    w_finish_st = st_valid && (st_addr == FINISH_ADDR);
    for (int k = 0; k < NUM_CHAN; k++) begin
      w_push[k]   = st_valid && (r_state == RUN) &&
                    (st_addr == (CONSOLE_BASE + (XLEN'(k) << 2)));
      w_empty[k]  = (r_wr[k] == r_rd[k]);
      w_full[k]   = (r_wr[k][AW] != r_rd[k][AW]) && (r_wr[k][AW-1:0] == r_rd[k][AW-1:0]);
      w_accept[k] = w_push[k] && !w_full[k];
      w_pop[k]    = r_con_valid[k] && con_ready[k];
      w_rd_nxt[k] = r_rd[k] + PW'(w_pop[k]);
    end
    w_all_empty = &w_empty;
    w_expire    = (wdt_limit != '0) && (r_wdt >= wdt_limit) && !retire;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RUN: begin
        if (w_finish_st) begin
          w_state_nxt = DRAIN;
        end else if (w_expire) begin
          w_state_nxt = HUNG;
        end else begin
          w_state_nxt = RUN;
        end
      end
      DRAIN: begin
        if (w_all_empty) begin
          w_state_nxt = DONE;
        end else begin
          w_state_nxt = DRAIN;
        end
      end
      DONE:    w_state_nxt = DONE;
      HUNG:    w_state_nxt = HUNG;
      default: w_state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= RUN;
      r_exit  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == RUN) && w_finish_st) begin
        r_exit <= st_data;
      end
    end
  end

  // Watchdog counts only in RUN; retire clears it and has priority over expiry.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wdt <= '0;
    end else if (r_state == RUN) begin
      if (retire) begin
        r_wdt <= '0;
      end else if (r_wdt != '1) begin
        r_wdt <= r_wdt + WDT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_CHAN; k++) begin
      if (w_accept[k]) begin
        r_mem[k][r_wr[k][AW-1:0]] <= st_data[7:0];
      end
    end
  end

  // Output stage holds the FIFO head; a new push shows one cycle later, a pop advances it at once.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int k = 0; k < NUM_CHAN; k++) begin
        r_wr[k] <= '0;
        r_rd[k] <= '0;
      end
      r_con_valid <= '0;
      r_con_data  <= '0;
      r_ovf       <= '0;
    end else begin
      for (int k = 0; k < NUM_CHAN; k++) begin
        if (w_accept[k]) begin
          r_wr[k] <= r_wr[k] + PW'(1);
        end
        r_rd[k]              <= w_rd_nxt[k];
        r_ovf[k]             <= r_ovf[k] | (w_push[k] & w_full[k]);
        r_con_valid[k]       <= (r_wr[k] != w_rd_nxt[k]);
        r_con_data[8*k +: 8] <= (r_wr[k] != w_rd_nxt[k]) ? r_mem[k][w_rd_nxt[k][AW-1:0]] : 8'h00;
      end
    end
  end

  assign con_valid    = r_con_valid;
  assign con_data     = r_con_data;
  assign con_overflow = r_ovf;
  assign finish       = (r_state == DONE);
  assign hang         = (r_state == HUNG);
  assign exit_code    = r_exit;

`ifdef HOST_MON_CYCLE_CNT_EN
  logic [31:0] r_cycle;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_cycle <= 32'h0;
    end else if (((r_state == RUN) || (r_state == DRAIN)) && (r_cycle != 32'hFFFF_FFFF)) begin
      r_cycle <= r_cycle + 32'h1;
    end
  end

  assign cycle_count = r_cycle;
`else
  assign cycle_count = 32'h0;
`endif

endmodule

// File: tb/tb_host_mmio_monitor.sv
// Self-checking bench for host_mmio_monitor: store table, console scoreboard and
// hand-written sequences for overflow, finish/drain, watchdog and reset corners.
module tb_host_mmio_monitor;
  localparam int          NCH      = 2;
  localparam int          DEPTH    = 8;
  localparam logic [31:0] CON_BASE = 32'h0020_0000;
  localparam logic [31:0] FIN_ADDR = 32'h1000_0000;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic            st_valid = 1'b0;
  logic [31:0]     st_addr = 32'h0;
  logic [31:0]     st_data = 32'h0;
  logic            retire = 1'b0;
  logic [31:0]     wdt_limit = 32'h0;
  logic [NCH-1:0]  con_valid;
  logic [8*NCH-1:0] con_data;
  logic [NCH-1:0]  con_ready = '0;
  logic [NCH-1:0]  con_overflow;
  logic            finish;
  logic [31:0]     exit_code;
  logic            hang;
  logic [31:0]     cycle_count;

  int errors = 0;
  int checks = 0;

  logic [7:0]     q0[$];
  logic [7:0]     q1[$];
  logic           model_run = 1'b1;
  logic [NCH-1:0] ovf_exp = '0;
  logic [31:0]    exp_exit = 32'h0;
  int             rx_cnt [NCH];

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  data;
    int          ch;
  } vec_t;
  vec_t tbl [8];

  host_mmio_monitor dut (
    .clk(clk), .rstn(rstn), .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data),
    .retire(retire), .wdt_limit(wdt_limit), .con_valid(con_valid), .con_data(con_data),
    .con_ready(con_ready), .con_overflow(con_overflow), .finish(finish),
    .exit_code(exit_code), .hang(hang), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_pop(input int k, input logic [7:0] d);
    if (k == 0) begin
      if (q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb0_extra: got byte %0h expected no byte", d);
      end else begin
        chk("sb0_data", d, q0.pop_front());
      end
    end else begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb1_extra: got byte %0h expected no byte", d);
      end else begin
        chk("sb1_data", d, q1.pop_front());
      end
    end
    rx_cnt[k]++;
  endtask

  // Scoreboard consumer: a byte leaves the DUT at the next edge when valid and ready are both high.
  always @(negedge clk) begin
    if (rstn) begin
      if (con_valid[0] && con_ready[0]) sb_pop(0, con_data[7:0]);
      if (con_valid[1] && con_ready[1]) sb_pop(1, con_data[15:8]);
    end
  end

  task automatic do_store(input logic [31:0] addr, input logic [31:0] data);
    int ch;
    ch = -1;
    for (int k = 0; k < NCH; k++) if (addr == CON_BASE + 32'(4 * k)) ch = k;
    if (model_run) begin
      if (addr == FIN_ADDR) begin
        model_run = 1'b0;
        exp_exit  = data;
      end else if (ch == 0) begin
        if (q0.size() < DEPTH) q0.push_back(data[7:0]); else ovf_exp[0] = 1'b1;
      end else if (ch == 1) begin
        if (q1.size() < DEPTH) q1.push_back(data[7:0]); else ovf_exp[1] = 1'b1;
      end
    end
    st_valid = 1'b1; st_addr = addr; st_data = data;
    step();
    st_valid = 1'b0; st_addr = 32'h0; st_data = 32'h0;
  endtask

  task automatic do_reset(input int n);
    rstn = 1'b0; st_valid = 1'b0; retire = 1'b0;
    repeat (n) step();
    q0.delete(); q1.delete();
    model_run = 1'b1; ovf_exp = '0; exp_exit = 32'h0;
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_valid"}, con_valid, 0);
    chk({tag, "_data"},  con_data, 0);
    chk({tag, "_ovf"},   con_overflow, 0);
    chk({tag, "_fin"},   finish, 0);
    chk({tag, "_exit"},  exit_code, 0);
    chk({tag, "_hang"},  hang, 0);
    chk({tag, "_cyc"},   cycle_count, 0);
  endtask

  task automatic drain_q1();
    int g;
    g = 0;
    con_ready[1] = 1'b1;
    while (q1.size() != 0 && g < 40) begin step(); g++; end
    chk("drain1_q", q1.size(), 0);
    repeat (2) step();
    chk("drain1_valid", con_valid[1], 0);
  endtask

  initial begin : timeout
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int exp_rx [NCH];
    int g;
    tbl[0] = '{32'h0020_0000, 8'h48, 0};
    tbl[1] = '{32'h0020_0000, 8'h69, 0};
    tbl[2] = '{32'h0020_0004, 8'hA5, 1};
    tbl[3] = '{32'h0020_0008, 8'h11, -1};
    tbl[4] = '{32'h0020_0002, 8'h22, -1};
    tbl[5] = '{32'h0000_0000, 8'h33, -1};
    tbl[6] = '{32'h0020_0004, 8'h5A, 1};
    tbl[7] = '{32'h1000_0004, 8'h77, -1};
    rx_cnt[0] = 0; rx_cnt[1] = 0;

    do_reset(2);
    reset_checks("rst0");
    rstn = 1'b1;

    // Latency: visible one edge after the storing edge; pop advances immediately.
    con_ready = 2'b00;
    do_store(CON_BASE, 32'hC1);
    chk("lat_n", con_valid[0], 0);
    do_store(CON_BASE, 32'hC2);
    chk("lat_n1_valid", con_valid[0], 1);
    chk("lat_n1_data", con_data[7:0], 8'hC1);
    step();
    chk("lat_hold", con_data[7:0], 8'hC1);
    con_ready = 2'b01;
    step();
    chk("pop_next_valid", con_valid[0], 1);
    chk("pop_next_data", con_data[7:0], 8'hC2);
    step();
    chk("pop_empty", con_valid[0], 0);

    // Table of store vectors, drained through the scoreboard.
    con_ready = 2'b11;
    exp_rx[0] = rx_cnt[0]; exp_rx[1] = rx_cnt[1];
    for (int i = 0; i < 8; i++) begin
      if (tbl[i].ch >= 0) exp_rx[tbl[i].ch]++;
      do_store(tbl[i].addr, {24'h0, tbl[i].data});
      repeat (3) step();
      chk($sformatf("tbl%0d_rx0", i), rx_cnt[0], exp_rx[0]);
      chk($sformatf("tbl%0d_rx1", i), rx_cnt[1], exp_rx[1]);
    end
    chk("tbl_ovf", con_overflow, ovf_exp);

    // Overflow: nine stores into an eight-deep FIFO with no pops.
    con_ready = 2'b00;
    for (int i = 1; i <= 9; i++) do_store(CON_BASE + 32'h4, 32'(i));
    step();
    chk("ovf_flag", con_overflow, ovf_exp);
    chk("ovf_flag_exp", ovf_exp, 2'b10);
    chk("ovf_head", con_data[15:8], 8'h01);
    drain_q1();
    // Full FIFO with a same-cycle pop still drops the push.
    con_ready = 2'b00;
    for (int i = 0; i < 8; i++) do_store(CON_BASE + 32'h4, 32'h80 + 32'(i));
    con_ready[1] = 1'b1;
    do_store(CON_BASE + 32'h4, 32'h88);
    drain_q1();
    chk("ovf_sticky", con_overflow, 2'b10);

    // Watchdog: periodic retire, disabled limit, retire/expiry tie, then expiry.
    wdt_limit = 32'd16; retire = 1'b1; step(); retire = 1'b0;
    chk("wdt_clear_big", hang, 0);
    for (int r = 0; r < 6; r++) begin
      repeat (9) step();
      retire = 1'b1; step(); retire = 1'b0;
    end
    chk("wdt_periodic", hang, 0);
    wdt_limit = 32'd0;
    repeat (40) step();
    chk("wdt_disabled", hang, 0);
    wdt_limit = 32'd16; retire = 1'b1; step(); retire = 1'b0;
    repeat (16) step();
    chk("wdt_pre_tie", hang, 0);
    retire = 1'b1; step(); retire = 1'b0;
    chk("wdt_tie", hang, 0);
    repeat (16) step();
    chk("wdt_16", hang, 0);
    step();
    chk("wdt_17", hang, 1);
    model_run = 1'b0;
    do_store(FIN_ADDR, 32'h77);
    do_store(CON_BASE, 32'h12);
    repeat (2) step();
    chk("hung_fin", finish, 0);
    chk("hung_exit", exit_code, exp_exit);
    chk("hung_con", con_valid, 0);
    chk("hung_sticky", hang, 1);

    // Finish with three bytes pending.
    wdt_limit = 32'd0;
    do_reset(2);
    reset_checks("rst1");
    rstn = 1'b1;
    con_ready = 2'b00;
    do_store(CON_BASE, 32'h31);
    do_store(CON_BASE, 32'h32);
    do_store(CON_BASE, 32'h33);
    do_store(FIN_ADDR, 32'h2A);
    chk("fin_exit", exit_code, 32'h2A);
    do_store(CON_BASE, 32'h99);
    step();
    chk("fin_wait", finish, 0);
    con_ready = 2'b01;
    g = 0;
    while (q0.size() != 0 && g < 20) begin step(); g++; end
    chk("fin_drain_q", q0.size(), 0);
    chk("fin_before", finish, 0);
    step();
    chk("fin_after", finish, 1);
    chk("fin_no_extra", con_valid, 0);
    chk("fin_exit_hold", exit_code, 32'h2A);
    do_store(CON_BASE, 32'hAB);
    repeat (2) step();
    chk("done_ignore", con_valid, 0);
    chk("done_sticky", finish, 1);

    // One-cycle reset while bytes pending in DRAIN.
    do_reset(2);
    rstn = 1'b1;
    con_ready = 2'b00;
    do_store(CON_BASE + 32'h4, 32'hE1);
    do_store(CON_BASE + 32'h4, 32'hE2);
    do_store(FIN_ADDR, 32'h55);
    chk("mid_exit", exit_code, 32'h55);
    do_reset(1);
    reset_checks("rst_mid");
    rstn = 1'b1;
    repeat (2) step();
    chk("mid_empty", con_valid, 0);

    // Finish with empty FIFOs: DRAIN then DONE on the next edge.
    con_ready = 2'b11;
    do_store(CON_BASE, 32'h5C);
    repeat (3) step();
    chk("mid_run_q", q0.size(), 0);
    do_store(FIN_ADDR, 32'hDEAD_BEEF);
    chk("fin0_n", finish, 0);
    chk("fin0_exit", exit_code, 32'hDEAD_BEEF);
    step();
    chk("fin0_n1", finish, 1);
`ifndef HOST_MON_CYCLE_CNT_EN
    chk("cyc_tied", cycle_count, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
